traffic_demand_loader: RTL and testbench
========================================

// Module: traffic_demand_loader
// PURPOSE
//   Front end of the two-way traffic light controller. Synchronises and debounces
//   the raw vehicle detectors for both approaches. Latches a pending-demand flag per
//   approach and computes each approach's next green duration from the traffic that
//   queued while it was red. Drives the controller's en1/en2 and ld1/ld2 inputs, and
//   reads the controller's phase back.
// PARAMETERS
//   DB_CYCLES  16   consecutive stable synchronised samples needed to flip a debounced sensor
//   TW         32   width of ld1/ld2 (matches controller countdown timers)
//   MIN_GREEN  100  green duration in ck cycles with no queued traffic
//   EXT_STEP   20   cycles added per queued-vehicle event
//   MAX_GREEN  400  saturation ceiling for ld1/ld2 (MIN_GREEN <= MAX_GREEN < 2**TW)
// PORTS
//   ck       in   1        clock, all logic on posedge
//   rst      in   1        synchronous reset, active-high
//   sensor1  in   1        raw detector, approach 1, asynchronous to ck
//   sensor2  in   1        raw detector, approach 2, asynchronous to ck
//   phase    in   2        controller state: 00 L1 green, 01 L1 yellow, 10 L2 green, 11 L2 yellow
//   en1      out  1        demand pending on approach 1
//   en2      out  1        demand pending on approach 2
//   ld1      out  TW       next green duration, approach 1
//   ld2      out  TW       next green duration, approach 2
// BEHAVIOUR
//   Reset (rst high at posedge ck)
//   - Clears sync flops, debounce counters, debounced levels, en1/en2, cnt1/cnt2.
//   - Sets ld1 = ld2 = MIN_GREEN and phase_q = 00.
//   - Any in-flight debounce is discarded. rst has priority over every other event.
//   Synchroniser
//   - 2-flop chain per sensor. sN_sync is the second flop.
//   Debounce, per approach
//   - dbN: debounced level. dcN: counter, 0..DB_CYCLES-1.
//   - If sN_sync == dbN: dcN <= 0.
//   - Else, if dcN == DB_CYCLES-1: dbN <= ~dbN and dcN <= 0.
//   - Else: dcN <= dcN + 1.
//   - Latency: raw edge to dbN change is 2 + DB_CYCLES edges.
//   - Any mismatch shorter than DB_CYCLES samples leaves dbN unchanged.
//   Event detection
//   - riseN = dbN & ~dbN_q, where dbN_q is dbN delayed one cycle.
//   - phase_q is phase registered one cycle.
//   - entry1 = (phase == 00) & (phase_q != 00).
//   - entry2 = (phase == 10) & (phase_q != 10).
//   Demand latch
//   - en1 is held 0 while phase == 00.
//   - Otherwise en1 sets to 1 when db1 == 1, and holds until phase returns to 00.
//   - en2 follows the same rule with phase == 10 and db2.
//   - en1/en2 are registered: they update one edge after the qualifying condition.
//   Queue counters (4-bit, saturate at 15)
//   - cnt1 increments on rise1 while phase[1] == 1 (approach 1 red).
//   - cnt1 clears on entry1. If entry1 and rise1 fall in the same cycle, the clear wins.
//   - cnt2 follows the same rule using rise2, phase[1] == 0, and entry2.
//   Duration outputs
//   - ld1 <= min(MIN_GREEN + EXT_STEP*cnt1, MAX_GREEN), updated only while phase[1] == 1.
//   - ld1 is frozen through L1 green and yellow, so it stays stable while the controller consumes it.
//   - ld2 follows the same rule, updated only while phase[1] == 0.
//   - The sum is computed in TW+5 bits, then saturated. ld lags cnt by one edge.
//   Phase handling
//   - Any phase transition, including illegal jumps, is handled purely through the
//     equations above.
//   - Nothing is assumed about phase ordering.
// TESTING
//   1. rst=1 for 2 cycles, sensors=0 -> en1=en2=0, ld1=ld2=100 on both cycles and after release.
//   2. phase=10, sensor1 high for 10 cycles then low -> db1, en1 stay 0; cnt1=0; ld1 stays 100.
//   3. phase=10, sensor1 rises at edge 0 and stays high -> db1=1 at edge 18;
//      cnt1=1 and en1=1 at edge 19; ld1=120 at edge 20.
//   4. phase=10, 20 debounced sensor1 pulses -> cnt1=15 and ld1=400.
//      Rerun with MAX_GREEN=300 -> ld1=300.
//   5. en1=1 and ld1=160, phase 11->00 -> next edge: en1=0, cnt1=0, ld1 still 160.
//      Phase 01->10 -> ld1=100 one edge later.
//   6. rst pulsed at cycle 10 of a 16-cycle debounce on sensor2, sensor2 held high ->
//      db2 rises 2+16 edges after rst deasserts, not before.

Source files
------------

// File: rtl/traffic_demand_loader.sv
// Front end of the two-way traffic light controller: sensor sync/debounce, demand latches,
// and per-approach green-duration computation from traffic queued while red.
module traffic_demand_loader #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned TW        = 32,
    parameter int unsigned MIN_GREEN = 100,
    parameter int unsigned EXT_STEP  = 20,
    parameter int unsigned MAX_GREEN = 400
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          sensor1,
    input  logic          sensor2,
    input  logic [1:0]    phase,
    output logic          en1,
    output logic          en2,
    output logic [TW-1:0] ld1,
    output logic [TW-1:0] ld2
);

    localparam int unsigned DcW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned SumW = TW + 5;
    localparam logic [DcW-1:0] DcMax = DcW'(DB_CYCLES - 1);

    // Index 0 is approach 1, index 1 is approach 2.
    logic [1:0]                s_meta_q, s_meta_d;
    logic [1:0]                s_sync_q, s_sync_d;
    logic [1:0]                db_q, db_d;
    logic [1:0]                db_prev_q, db_prev_d;
    logic [1:0][DcW-1:0]       dc_q, dc_d;
    logic [1:0]                en_q, en_d;
    logic [1:0][3:0]           cnt_q, cnt_d;
    logic [1:0][TW-1:0]        ld_q, ld_d;
    logic [1:0]                phase_q, phase_d;

    logic [1:0]                green;
    logic [1:0]                entry;
    logic [1:0]                red;
    logic [1:0]                rise;
    logic [1:0][SumW-1:0]      sum;

    always_comb begin
        green[0] = (phase == 2'b00);
        green[1] = (phase == 2'b10);
        entry[0] = green[0] & (phase_q != 2'b00);
        entry[1] = green[1] & (phase_q != 2'b10);
        red[0]   = phase[1];
        red[1]   = ~phase[1];
        rise     = db_q & ~db_prev_q;
    end

    always_comb begin
        s_meta_d  = {sensor2, sensor1};
        s_sync_d  = s_meta_q;
        db_prev_d = db_q;
        phase_d   = phase;
        db_d      = db_q;
        dc_d      = dc_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        ld_d      = ld_q;
        sum       = '0;
        for (int i = 0; i < 2; i++) begin
            if (s_sync_q[i] == db_q[i]) begin
                dc_d[i] = '0;
            end else if (dc_q[i] == DcMax) begin
                db_d[i] = ~db_q[i];
                dc_d[i] = '0;
            end else begin
                dc_d[i] = dc_q[i] + DcW'(1);
            end

            en_d[i] = green[i] ? 1'b0 : (en_q[i] | db_q[i]);

            // Clearing on green entry takes precedence over a coincident arrival.
            if (entry[i]) begin
                cnt_d[i] = 4'd0;
            end else if (rise[i] && red[i] && (cnt_q[i] != 4'hf)) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end

            sum[i] = SumW'(MIN_GREEN) + SumW'(EXT_STEP) * SumW'(cnt_q[i]);
            // Frozen while this approach is green/yellow so the controller sees a stable load.
            if (red[i]) begin
                ld_d[i] = (sum[i] > SumW'(MAX_GREEN)) ? TW'(MAX_GREEN) : sum[i][TW-1:0];
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            s_meta_q  <= '0;
            s_sync_q  <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            dc_q      <= '0;
            en_q      <= '0;
            cnt_q     <= '0;
            ld_q      <= {TW'(MIN_GREEN), TW'(MIN_GREEN)};
            phase_q   <= 2'b00;
        end else begin
            s_meta_q  <= s_meta_d;
            s_sync_q  <= s_sync_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            dc_q      <= dc_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            ld_q      <= ld_d;
            phase_q   <= phase_d;
        end
    end

    assign en1 = en_q[0];
    assign en2 = en_q[1];
    assign ld1 = ld_q[0];
    assign ld2 = ld_q[1];

endmodule

// File: tb/tb_traffic_demand_loader.sv
// Bench for traffic_demand_loader: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the sensor-to-duration path.
module tb_traffic_demand_loader;

    localparam int unsigned DB   = 16;
    localparam int unsigned TW   = 32;
    localparam int unsigned MIN  = 100;
    localparam int unsigned EXT  = 20;
    localparam int unsigned MAXA = 400;
    localparam int unsigned MAXB = 300;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          sensor1 = 1'b0;
    logic          sensor2 = 1'b0;
    logic [1:0]    phase = 2'b00;
    logic          en1, en2, en1_b, en2_b;
    logic [TW-1:0] ld1, ld2, ld1_b, ld2_b;

    int n_cmp  = 0;
    int n_fail = 0;

    traffic_demand_loader #(
        .DB_CYCLES(DB), .TW(TW), .MIN_GREEN(MIN), .EXT_STEP(EXT), .MAX_GREEN(MAXA)
    ) dut (
        .ck(ck), .rst(rst), .sensor1(sensor1), .sensor2(sensor2), .phase(phase),
        .en1(en1), .en2(en2), .ld1(ld1), .ld2(ld2)
    );

    traffic_demand_loader #(
        .DB_CYCLES(DB), .TW(TW), .MIN_GREEN(MIN), .EXT_STEP(EXT), .MAX_GREEN(MAXB)
    ) dut_b (
        .ck(ck), .rst(rst), .sensor1(sensor1), .sensor2(sensor2), .phase(phase),
        .en1(en1_b), .en2(en2_b), .ld1(ld1_b), .ld2(ld2_b)
    );

    always #5 ck = ~ck;

    // Behavioural model, one entry per approach.
    bit          m_raw[2];
    bit          m_sync[2];
    bit          m_db[2];
    bit          m_db_prev[2];
    bit          m_en[2];
    int          m_cnt[2];
    int          m_last_agree[2];
    logic [31:0] m_lda[2];
    logic [31:0] m_ldb[2];
    bit [1:0]    m_ph;
    int          m_edge = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_update(input bit s1, input bit s2, input bit [1:0] ph, input bit r);
        bit   sens[2];
        bit   is_green, was_green, is_red, rise;
        sens[0] = s1;
        sens[1] = s2;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_raw[i] = 0; m_sync[i] = 0; m_db[i] = 0; m_db_prev[i] = 0; m_en[i] = 0;
                m_cnt[i] = 0; m_lda[i] = MIN; m_ldb[i] = MIN; m_last_agree[i] = m_edge;
            end else begin
                is_green  = (i == 0) ? (ph == 2'b00) : (ph == 2'b10);
                was_green = (i == 0) ? (m_ph == 2'b00) : (m_ph == 2'b10);
                is_red    = (i == 0) ? ph[1] : !ph[1];
                rise      = m_db[i] && !m_db_prev[i];
                if (is_red) begin
                    m_lda[i] = imin(MIN + EXT * m_cnt[i], MAXA);
                    m_ldb[i] = imin(MIN + EXT * m_cnt[i], MAXB);
                end
                if (is_green && !was_green) m_cnt[i] = 0;
                else if (rise && is_red)    m_cnt[i] = imin(m_cnt[i] + 1, 15);
                m_en[i] = is_green ? 0 : (m_en[i] || m_db[i]);
                m_db_prev[i] = m_db[i];
                // Level flips once DB consecutive synchronised samples have disagreed with it.
                if (m_sync[i] == m_db[i]) begin
                    m_last_agree[i] = m_edge;
                end else if (m_edge - m_last_agree[i] == DB) begin
                    m_db[i] = !m_db[i];
                    m_last_agree[i] = m_edge;
                end
                m_sync[i] = m_raw[i];
                m_raw[i]  = sens[i];
            end
        end
        m_ph = r ? 2'b00 : ph;
        m_edge++;
    endtask

    task automatic step(input bit s1, input bit s2, input bit [1:0] ph);
        sensor1 = s1;
        sensor2 = s2;
        phase   = ph;
        @(posedge ck);
        model_update(s1, s2, ph, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 2'b00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rst = 1'b0;
            step(0, 0, 2'b00);
            n_cmp++;
            if ({en1, en2} !== 2'b00) begin
                n_fail++; $display("FAIL reset_en c=%0d: got %b%b expected 00", c, en1, en2);
            end
            n_cmp++;
            if (ld1 !== 32'd100 || ld2 !== 32'd100) begin
                n_fail++; $display("FAIL reset_ld c=%0d: got %0d/%0d expected 100", c, ld1, ld2);
            end
        end
    endtask

    task automatic test_short_pulse();
        do_reset();
        step(0, 0, 2'b10);
        for (int c = 0; c < 40; c++) begin
            step((c < 10), 0, 2'b10);
            n_cmp++;
            if (en1 !== 1'b0 || ld1 !== 32'd100) begin
                n_fail++;
                $display("FAIL short_pulse c=%0d: got en1=%b ld1=%0d expected 0/100", c, en1, ld1);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        step(0, 0, 2'b10);
        for (int e = 1; e <= 20; e++) begin
            step(1, 0, 2'b10);
            n_cmp++;
            if (en1 !== (e >= 19)) begin
                n_fail++; $display("FAIL latency_en1 e=%0d: got %b expected %b", e, en1, e >= 19);
            end
            if (e >= 19) begin
                n_cmp++;
                if (ld1 !== ((e == 20) ? 32'd120 : 32'd100)) begin
                    n_fail++; $display("FAIL latency_ld1 e=%0d: got %0d", e, ld1);
                end
            end
        end
    endtask

    task automatic pulse1(input bit [1:0] ph);
        for (int c = 0; c < 40; c++) step((c < 20), 0, ph);
    endtask

    task automatic test_saturation();
        int exp_a, exp_b;
        do_reset();
        step(0, 0, 2'b10);
        for (int p = 1; p <= 20; p++) begin
            pulse1(2'b10);
            exp_a = imin(MIN + EXT * imin(p, 15), MAXA);
            exp_b = imin(MIN + EXT * imin(p, 15), MAXB);
            n_cmp++;
            if (ld1 !== 32'(exp_a) || ld1_b !== 32'(exp_b)) begin
                n_fail++;
                $display("FAIL saturation p=%0d: got %0d/%0d expected %0d/%0d",
                         p, ld1, ld1_b, exp_a, exp_b);
            end
        end
        n_cmp++;
        if (ld1 !== 32'd400 || ld1_b !== 32'd300 || en1 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation_final: got ld1=%0d ld1_b=%0d en1=%b expected 400/300/1",
                     ld1, ld1_b, en1);
        end
    endtask

    task automatic test_release();
        do_reset();
        step(0, 0, 2'b11);
        for (int p = 0; p < 3; p++) pulse1(2'b11);
        n_cmp++;
        if (en1 !== 1'b1 || ld1 !== 32'd160) begin
            n_fail++; $display("FAIL release_pre: got en1=%b ld1=%0d expected 1/160", en1, ld1);
        end
        for (int c = 0; c < 6; c++) begin
            step(0, 0, (c < 3) ? 2'b00 : 2'b01);
            n_cmp++;
            if (en1 !== 1'b0 || ld1 !== 32'd160) begin
                n_fail++;
                $display("FAIL release_hold c=%0d: got en1=%b ld1=%0d expected 0/160", c, en1, ld1);
            end
        end
        step(0, 0, 2'b10);
        n_cmp++;
        if (ld1 !== 32'd100) begin
            n_fail++; $display("FAIL release_reload: got %0d expected 100", ld1);
        end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        step(0, 0, 2'b00);
        for (int c = 0; c < 12; c++) step(0, 1, 2'b00);
        rst = 1'b1;
        step(0, 1, 2'b00);
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step(0, 1, 2'b00);
            n_cmp++;
            if (en2 !== (e >= 19)) begin
                n_fail++; $display("FAIL mid_reset_en2 e=%0d: got %b expected %b", e, en2, e >= 19);
            end
        end
    endtask

    task automatic test_random();
        bit       s1 = 0, s2 = 0;
        bit [1:0] ph = 2'b00;
        int       h1 = 1, h2 = 1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (--h1 == 0) begin s1 = $urandom_range(0, 1); h1 = $urandom_range(1, 40); end
            if (--h2 == 0) begin s2 = $urandom_range(0, 1); h2 = $urandom_range(1, 40); end
            if ($urandom_range(0, 49) == 0) ph = 2'($urandom_range(0, 3));
            step(s1, s2, ph);
            n_cmp++;
            if (en1 !== m_en[0] || en2 !== m_en[1]) begin
                n_fail++;
                $display("FAIL rand_en c=%0d: got %b%b expected %b%b", c, en1, en2, m_en[0], m_en[1]);
            end
            n_cmp++;
            if (ld1 !== m_lda[0] || ld2 !== m_lda[1]) begin
                n_fail++;
                $display("FAIL rand_ld c=%0d: got %0d/%0d expected %0d/%0d",
                         c, ld1, ld2, m_lda[0], m_lda[1]);
            end
            n_cmp++;
            if (ld1_b !== m_ldb[0] || ld2_b !== m_ldb[1] || en1_b !== m_en[0]) begin
                n_fail++;
                $display("FAIL rand_ld_b c=%0d: got %0d/%0d expected %0d/%0d",
                         c, ld1_b, ld2_b, m_ldb[0], m_ldb[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_latency();
        test_saturation();
        test_release();
        test_reset_mid_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
